// File: rtl/product_result_writer.sv
// Captures the multiplier product stream into a 16 x 32 result memory with fill/overflow status.
// Optional running checksum of accepted words is enabled by defining PRW_CHECKSUM_EN.
module product_result_writer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              clear,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              overflow
`ifdef PRW_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FILL,
        S_FULL
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_done;
    logic              r_overflow;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_mem [DEPTH];
`ifdef PRW_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;
`endif

    // Reset and clear both abort capture, so a word arriving with either is dropped.
    logic w_accept;
    assign w_accept = in_valid && !reset && !clear && (r_state != S_FULL);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_state    <= S_EMPTY;
            r_wr_addr  <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
`ifdef PRW_CHECKSUM_EN
            r_checksum <= '0;
`endif
        end else begin
            case (r_state)
                S_EMPTY, S_FILL: begin
                    if (in_valid) begin
                        // NOTE: non-blocking assignments here, so every comparison below sees the pre-edge count.
                        r_wr_addr <= r_wr_addr + 1'b1;
                        r_count   <= r_count + 1'b1;
`ifdef PRW_CHECKSUM_EN
                        r_checksum <= r_checksum + in_data;
`endif
                        if (r_count == LAST_CNT) begin
                            r_state <= S_FULL;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end
                S_FULL: begin
                    if (in_valid) begin
                        r_overflow <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                end
            endcase
        end
    end

    // NOTE: the memory array has no reset; clearing it would defeat block-RAM inference and results must survive reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_addr] <= in_data;
        end
    end

    // Read-first: a same-address write in this cycle lands after the old word is sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data  = r_rd_data;
    assign wr_addr  = r_wr_addr;
    assign count    = r_count;
    assign done     = r_done;
    assign overflow = r_overflow;
`ifdef PRW_CHECKSUM_EN
    assign checksum = r_checksum;
`endif

endmodule

// File: doc/product_result_writer.md
# product_result_writer

Write-side companion to the multiplier datapath. It captures the product stream (32-bit product plus its valid strobe) into an internal 16 x 32 result memory at sequential addresses and reports fill count and completion. A registered readback port lets the host or testbench check the stored results. It sits directly downstream of the multiplier and is the destination end of the product/valid interface.

## Interface
- DATA_W, 32, product/word width
- ADDR_W, 4, result memory address width; depth = 2**ADDR_W = 16

- clk  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high; clears all state registers (not memory contents)
- in_data  in  DATA_W  product word from multiplier
- in_valid  in  1  in_data valid this cycle (multiplier delayed-enable strobe)
- clear  in  1  synchronous restart of capture: count/address to 0, flags cleared, memory contents kept
- rd_addr  in  ADDR_W  readback address
- rd_data  out  DATA_W  registered readback data
- wr_addr  out  ADDR_W  next write address
- count  out  ADDR_W+1  words stored, 0..16
- done  out  1  memory full (count == 16)
- overflow  out  1  sticky: valid word arrived while full
- checksum  out  DATA_W  only when PRW_CHECKSUM_EN is defined

## Operation
- FSM states:
  - EMPTY: count == 0.
  - FILL: 0 < count < 16.
  - FULL: count == 16.
- EMPTY -> FILL on an accepted word.
- FILL -> FULL on the 16th accepted word.
- Any state -> EMPTY on clear or reset.
- Accept: in_valid high in EMPTY or FILL. Effects:
  - mem[wr_addr] <= in_data
  - wr_addr <= wr_addr + 1, modulo 16
  - count <= count + 1
- EMPTY accepts the first word directly, so no cycle is lost.
- FULL: in_valid is ignored. No write occurs, wr_addr holds at 0 after wrapping, and overflow is set to 1. overflow stays 1 until clear or reset.
- clear and in_valid in the same cycle: clear wins and the word is dropped.
- reset and clear: identical effect on registers. reset has priority over everything.
- Reset/clear values: wr_addr=0, count=0, done=0, overflow=0, checksum=0, rd_data=0 (reset only; clear leaves rd_data alone). Memory is never cleared.
- Readback: rd_data <= mem[rd_addr] every cycle, regardless of state.
- Read and write to the same address in the same cycle returns the old contents (read-first).
- in_data is treated as unsigned; no width conversion.

## Timing
- Write latency: the word is in memory after the edge that samples in_valid.
- count, wr_addr and done update on that same edge. done is registered and high from the cycle after the 16th accept.
- Readback latency: 1 cycle from rd_addr to rd_data.
- A word written at edge N is readable on rd_data after edge N+1 if rd_addr points to it during cycle N+1.
- Back-to-back in_valid every cycle is supported. Gaps of any length are allowed.
- No backpressure: the upstream multiplier cannot stall. Words arriving while full are lost and are flagged only by overflow.
- Reset mid-fill: partial data stays in memory, but count restarts at 0 and later words overwrite from address 0.

## Configuration
- PRW_CHECKSUM_EN defined:
  - checksum port exists.
  - On each accepted word: checksum <= checksum + in_data, modulo 2**32.
  - Cleared by reset/clear. Dropped words are not added.
- PRW_CHECKSUM_EN undefined: checksum port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1 and random data -> count=0, wr_addr=0, done=0, overflow=0, rd_data=0, no write occurs.
- Full burst: in_valid=1 for 16 cycles with data 1..16 -> done=1 the cycle after the last word, count=16. Readback of addr 0..15 returns 1..16 at 1-cycle latency. Checksum (if enabled) = 0x88.
- Gapped stream: valid pattern 1,0,0,1,0,1 with data 0xA,x,x,0xB,x,0xC -> count=3, mem[0..2]=0xA,0xB,0xC, wr_addr=3.
- Overflow: 17th word 0xDEAD after full -> overflow=1 and sticky, count stays 16, mem[0] still 1. Then clear -> overflow=0, count=0, mem intact.
- Clear mid-fill: after 5 words, assert clear with in_valid=1 and data 0x55 -> word dropped, count=0. The next word 0x66 lands at addr 0.
- Read-during-write: rd_addr=2 while writing 0x77 to addr 2 (old value 0xC) -> rd_data=0xC next cycle and 0x77 the cycle after.
